// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word fetches to instruction memory and
// buffers returned instructions with their PCs for decode; redirects discard in-flight fetches.
module fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 3,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  localparam int CW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int FW = $clog2(FIFO_DEPTH);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_live;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_fcnt;
  logic [QW-1:0] r_pq_wr;
  logic [QW-1:0] r_pq_rd;
  logic [FW-1:0] r_f_wr;
  logic [FW-1:0] r_f_rd;
  logic [31:0]   r_pq_pc   [MAX_OUTSTANDING];
  logic [31:0]   r_f_pc    [FIFO_DEPTH];
  logic [31:0]   r_f_instr [FIFO_DEPTH];

  logic [CW:0]   w_inflight;
  logic [CW:0]   w_occupied;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_rsp_any;
  logic          w_rsp_drop;
  logic          w_rsp_live;
  logic          w_f_push;
  logic          w_id_fire;
  logic          w_unused_ok;

  function automatic logic [QW-1:0] pq_inc(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [FW-1:0] f_inc(input logic [FW-1:0] p);
    return (p == FW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Issue depends only on registered counts so a live response always has a FIFO slot.
  assign w_inflight  = {1'b0, r_live} + {1'b0, r_drop};
  assign w_occupied  = {1'b0, r_live} + {1'b0, r_fcnt};
  assign w_req_valid = !rst && !redirect_valid
                       && (w_inflight < (CW+1)'(MAX_OUTSTANDING))
                       && (w_occupied < (CW+1)'(FIFO_DEPTH));
  assign w_req_fire  = w_req_valid && imem_req_ready;
  assign w_rsp_any   = imem_rsp_valid && ((r_drop != '0) || (r_live != '0));
  assign w_rsp_drop  = imem_rsp_valid && (r_drop != '0);
  assign w_rsp_live  = imem_rsp_valid && (r_drop == '0) && (r_live != '0);
  assign w_f_push    = w_rsp_live && !redirect_valid;
  assign w_id_fire   = (r_fcnt != '0) && id_ready;
  assign w_unused_ok = &{1'b0, redirect_pc[1:0]};

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign id_valid       = (r_fcnt != '0);
  assign id_pc          = id_valid ? r_f_pc[r_f_rd] : 32'h0;
  assign id_instr       = id_valid ? r_f_instr[r_f_rd] : 32'h0;
  assign id_pc_plus4    = id_pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_live  <= '0;
      r_drop  <= '0;
      r_fcnt  <= '0;
      r_pq_wr <= '0;
      r_pq_rd <= '0;
      r_f_wr  <= '0;
      r_f_rd  <= '0;
    end else if (redirect_valid) begin
      // Every live fetch becomes a drop, less the one whose response lands this cycle.
      r_pc    <= {redirect_pc[31:2], 2'b00};
      r_drop  <= r_drop + r_live - CW'(w_rsp_any);
      r_live  <= '0;
      r_fcnt  <= '0;
      r_pq_wr <= '0;
      r_pq_rd <= '0;
      r_f_wr  <= '0;
      r_f_rd  <= '0;
    end else begin
      if (w_req_fire) begin
        r_pc    <= r_pc + 32'd4;
        r_pq_wr <= pq_inc(r_pq_wr);
      end
      if (w_rsp_live) begin
        r_pq_rd <= pq_inc(r_pq_rd);
        r_f_wr  <= f_inc(r_f_wr);
      end
      if (w_id_fire) begin
        r_f_rd <= f_inc(r_f_rd);
      end
      r_live <= r_live + CW'(w_req_fire) - CW'(w_rsp_live);
      r_drop <= r_drop - CW'(w_rsp_drop);
      r_fcnt <= r_fcnt + CW'(w_rsp_live) - CW'(w_id_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_pq_pc[r_pq_wr] <= r_pc;
    end
    if (w_f_push) begin
      r_f_pc[r_f_wr]    <= r_pq_pc[r_pq_rd];
      r_f_instr[r_f_wr] <= imem_rsp_data;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the core: owns the PC, issues word requests to instruction memory, and buffers returned instructions with their PCs for the decode stage. Decode slices each delivered instruction for the register file, control decoder and the immediate extend unit. Handles branch/jump redirects by discarding in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- FIFO_DEPTH, 3, IF/ID instruction buffer entries (≥2)
- MAX_OUTSTANDING, 2, max imem requests in flight (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response valid, in request order, ≥1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  branch/jump resolved to new PC
- redirect_pc  in  32  redirect target; bits [1:0] ignored, treated as 0
- id_valid  out  1  instruction available to decode
- id_ready  in  1  decode accepts
- id_instr  out  32  instruction
- id_pc  out  32  its PC
- id_pc_plus4  out  32  id_pc + 4, mod 2^32

## Operation
- State: pc; live (accepted, not yet returned, to be kept); drop (accepted, to be discarded); pending-PC queue (MAX_OUTSTANDING deep, PCs of live requests); output FIFO of {pc, instr}, count fcnt.
- Issue: imem_req_valid = !rst_state && !redirect_valid && (live+drop < MAX_OUTSTANDING) && (live+fcnt < FIFO_DEPTH). Uses registered counts only; no combinational path from id_ready or imem_rsp_valid.
- imem_req_addr = pc. On valid&&ready: push pc into pending queue, live+1, pc <= pc+4 (wraps 0xFFFF_FFFC -> 0).
- Response: if drop>0, drop-1, data discarded. Else if live>0: pop pending PC, push {pc, imem_rsp_data} to FIFO, live-1. Response with live=drop=0 ignored.
- Output: id_valid = fcnt!=0; id_* from FIFO head; pop on id_valid&&id_ready. Push and pop same cycle legal, fcnt unchanged.
- Redirect (highest priority, single cycle): pc <= {redirect_pc[31:2],2'b00}; FIFO flushed (fcnt=0, this cycle's push/pop discarded); pending queue cleared; drop <= drop + live − (response consumed this cycle ? 1 : 0), live <= 0; no request issued this cycle. Back-to-back redirects: last one wins, drop accumulates correctly.
- Space guarantee: live+fcnt ≤ FIFO_DEPTH always, so a live response never finds the FIFO full; overflow is impossible by construction.

## Timing
- Reset (async assert): pc=RESET_PC, live=drop=0, fcnt=0; imem_req_valid=0, id_valid=0, id_instr/id_pc=0, id_pc_plus4=4 while rst high.
- First cycle after rst deasserts: imem_req_valid=1, imem_req_addr=RESET_PC.
- Response in cycle N -> id_valid in N+1 (registered FIFO write).
- 1-cycle memory latency, ready always 1, id_ready always 1: one instruction per cycle sustained; request-to-id_valid latency 2 cycles.
- Redirect in cycle N: first request to new target in cycle N+1; id_valid=0 in N+1; earliest target instruction at decode in N+3 with 1-cycle memory.
- Reset asserted mid-operation: all state cleared immediately; responses arriving after reset to pre-reset requests are the memory's responsibility (memory is reset with the core).
- imem_req_valid deasserts without handshake only on redirect_valid or reset.

## Test plan
- Reset release, memory returns word = addr, ready=1, id_ready=1 -> id_pc 0x0,0x4,0x8... one per cycle from cycle 2, id_instr==id_pc, id_pc_plus4==id_pc+4.
- id_ready=0 for 10 cycles mid-stream -> exactly FIFO_DEPTH entries buffered, imem_req_valid drops once live+fcnt=3, no instruction lost or duplicated on release.
- Memory latency 3 cycles, 2 requests in flight, redirect_pc=0x100 -> both old responses discarded, next id_pc=0x100, then 0x104.
- Redirect same cycle as a live response and id_valid&&id_ready -> response and FIFO contents dropped, drop count correct, next id_pc = target.
- redirect_pc=0x203 -> imem_req_addr=0x200; pc at 0xFFFF_FFFC -> next fetch 0x0000_0000, id_pc_plus4=0x0.
- rst asserted mid-stream with fcnt=2 -> id_valid=0 immediately (async), after release fetch restarts at RESET_PC.
